// File: rtl/rd_scoreboard_pkg.sv
// rd_scoreboard_pkg: shared CPU register-file constants and destination select helper
package rd_scoreboard_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  localparam logic [4:0] OPC_RS1_DEST = 5'b01010;
  function automatic logic [REG_ADDR_W-1:0] sel_dest(input logic [6:0] opcode, input logic [REG_ADDR_W-1:0] rd, input logic [REG_ADDR_W-1:0] rs1);
    return (opcode[6:2] == OPC_RS1_DEST) ? rs1 : rd;
  endfunction
endpackage

// File: rtl/rd_scoreboard_if.sv
// rd_scoreboard_if: decode/writeback handshake into the register-write scoreboard
interface rd_scoreboard_if;
  import rd_scoreboard_pkg::*;
  logic                  flush_i;
  logic                  issue_valid_i;
  logic                  issue_wen_i;
  logic [REG_ADDR_W-1:0] issue_rd_addr_i;
  logic [REG_ADDR_W-1:0] issue_rs1_addr_i;
  logic [REG_ADDR_W-1:0] issue_rs2_addr_i;
  logic                  issue_rs1_use_i;
  logic                  issue_rs2_use_i;
  logic                  wb_valid_i;
  logic [REG_ADDR_W-1:0] wb_rd_addr_i;
  logic                  stall_o;
  logic                  issue_ack_o;
  logic [NUM_REGS-1:0]   busy_o;
  logic                  err_o;
  modport master (
    output flush_i, issue_valid_i, issue_wen_i, issue_rd_addr_i, issue_rs1_addr_i,
           issue_rs2_addr_i, issue_rs1_use_i, issue_rs2_use_i, wb_valid_i, wb_rd_addr_i,
    input  stall_o, issue_ack_o, busy_o, err_o
  );
  modport slave (
    input  flush_i, issue_valid_i, issue_wen_i, issue_rd_addr_i, issue_rs1_addr_i,
           issue_rs2_addr_i, issue_rs1_use_i, issue_rs2_use_i, wb_valid_i, wb_rd_addr_i,
    output stall_o, issue_ack_o, busy_o, err_o
  );
endinterface

// File: rtl/rd_scoreboard_rd_counter.sv
// rd_counter: saturating pending-write counter for one register
module rd_counter #(
  parameter int MAX = 3,
  parameter int CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             acq_i,
  input  logic             rel_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             nz_o,
  output logic             unf_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic rel_ok, acq_ok;
  assign nz_o = cnt_q != '0;
  assign unf_o = rel_i & ~nz_o;
  assign rel_ok = rel_i & nz_o;
  assign acq_ok = acq_i & ((cnt_q != CNT_W'(MAX)) | rel_ok);
  assign cnt_d = flush_i ? '0 : cnt_q + CNT_W'(acq_ok) - CNT_W'(rel_ok);
  assign cnt_o = cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/rd_scoreboard.sv
// rd_scoreboard: per-register pending-write tracking with decode stall and writeback bypass
module rd_scoreboard
  import rd_scoreboard_pkg::*;
#(
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_W = 2
) (
  input logic clk_i,
  input logic rst_i,
  rd_scoreboard_if.slave bus
);
  logic [NUM_REGS-1:0] rel, nz, unf;
  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [CNT_W-1:0] eff [NUM_REGS];
  logic err_q, err_d;
  logic st_rs1, st_rs2, st_rd;
  assign cnt[0] = '0;
  assign nz[0] = 1'b0;
  assign unf[0] = 1'b0;
  assign rel[0] = 1'b0;
  for (genvar n = 0; n < NUM_REGS; n++) begin : g_eff
    // A release on a zero count is an error, not a bypass
    assign eff[n] = cnt[n] - CNT_W'(rel[n] & nz[n]);
  end
  for (genvar n = 1; n < NUM_REGS; n++) begin : g_cnt
    assign rel[n] = bus.wb_valid_i & (bus.wb_rd_addr_i == REG_ADDR_W'(n));
    rd_counter #(.MAX(MAX_INFLIGHT), .CNT_W(CNT_W)) u_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .flush_i(bus.flush_i),
      .acq_i  (bus.issue_ack_o & bus.issue_wen_i & (bus.issue_rd_addr_i == REG_ADDR_W'(n))),
      .rel_i  (rel[n]),
      .cnt_o  (cnt[n]),
      .nz_o   (nz[n]),
      .unf_o  (unf[n])
    );
  end
  assign st_rs1 = bus.issue_rs1_use_i & (eff[bus.issue_rs1_addr_i] != '0);
  assign st_rs2 = bus.issue_rs2_use_i & (eff[bus.issue_rs2_addr_i] != '0);
  assign st_rd = bus.issue_wen_i & (bus.issue_rd_addr_i != '0) & (eff[bus.issue_rd_addr_i] == CNT_W'(MAX_INFLIGHT));
  assign bus.stall_o = bus.issue_valid_i & (st_rs1 | st_rs2 | st_rd);
  assign bus.issue_ack_o = bus.issue_valid_i & ~bus.stall_o;
  assign bus.busy_o = nz;
  assign err_d = err_q | ((|unf) & ~bus.flush_i);
  assign bus.err_o = err_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else err_q <= err_d;
  end
endmodule

// File: tb/tb_rd_scoreboard.sv
// tb_rd_scoreboard: directed checks of stall, bypass, saturation, underflow and flush
module tb_rd_scoreboard;
  logic clk = 0;
  logic rst = 1;
  int tests = 0;
  int fails = 0;
  rd_scoreboard_if bus();
  rd_scoreboard #(.MAX_INFLIGHT(3), .CNT_W(2)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic idle();
    bus.flush_i = 0;
    bus.issue_valid_i = 0;
    bus.issue_wen_i = 0;
    bus.issue_rd_addr_i = 0;
    bus.issue_rs1_addr_i = 0;
    bus.issue_rs2_addr_i = 0;
    bus.issue_rs1_use_i = 0;
    bus.issue_rs2_use_i = 0;
    bus.wb_valid_i = 0;
    bus.wb_rd_addr_i = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic issue_wr(input logic [4:0] rd);
    bus.issue_valid_i = 1;
    bus.issue_wen_i = 1;
    bus.issue_rd_addr_i = rd;
    #1;
  endtask

  task automatic wb(input logic [4:0] rd);
    bus.wb_valid_i = 1;
    bus.wb_rd_addr_i = rd;
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    idle();
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (bus.busy_o !== 32'h0) begin fails++; $display("FAIL reset_busy got %h exp %h", bus.busy_o, 32'h0); end
    tests++; if (bus.err_o !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", bus.err_o); end
    tests++; if (bus.stall_o !== 1'b0) begin fails++; $display("FAIL reset_stall got %b exp 0", bus.stall_o); end
    tests++; if (bus.issue_ack_o !== 1'b0) begin fails++; $display("FAIL reset_ack got %b exp 0", bus.issue_ack_o); end
  endtask

  task automatic test_raw_bypass();
    issue_wr(5);
    tests++; if (bus.issue_ack_o !== 1'b1) begin fails++; $display("FAIL raw_issue_ack got %b exp 1", bus.issue_ack_o); end
    tick();
    tests++; if (bus.busy_o !== 32'h20) begin fails++; $display("FAIL raw_busy got %h exp %h", bus.busy_o, 32'h20); end
    bus.issue_valid_i = 1;
    bus.issue_rs1_addr_i = 5;
    bus.issue_rs1_use_i = 1;
    #1;
    tests++; if (bus.stall_o !== 1'b1) begin fails++; $display("FAIL raw_stall got %b exp 1", bus.stall_o); end
    wb(5);
    tests++; if (bus.stall_o !== 1'b0) begin fails++; $display("FAIL raw_bypass_stall got %b exp 0", bus.stall_o); end
    tests++; if (bus.issue_ack_o !== 1'b1) begin fails++; $display("FAIL raw_bypass_ack got %b exp 1", bus.issue_ack_o); end
    tick();
    tests++; if (bus.busy_o !== 32'h0) begin fails++; $display("FAIL raw_release_busy got %h exp %h", bus.busy_o, 32'h0); end
    bus.issue_valid_i = 1;
    bus.issue_rs2_addr_i = 5;
    bus.issue_rs2_use_i = 1;
    #1;
    tests++; if (bus.stall_o !== 1'b0) begin fails++; $display("FAIL raw_rs2_free got %b exp 0", bus.stall_o); end
    idle();
  endtask

  task automatic test_x0();
    issue_wr(0);
    tests++; if (bus.stall_o !== 1'b0) begin fails++; $display("FAIL x0_issue_stall got %b exp 0", bus.stall_o); end
    tick();
    tests++; if (bus.busy_o !== 32'h0) begin fails++; $display("FAIL x0_busy got %h exp %h", bus.busy_o, 32'h0); end
    bus.issue_valid_i = 1;
    bus.issue_rs1_use_i = 1;
    bus.issue_rs1_addr_i = 0;
    #1;
    tests++; if (bus.stall_o !== 1'b0) begin fails++; $display("FAIL x0_rs1_stall got %b exp 0", bus.stall_o); end
    idle();
  endtask

  task automatic test_max_inflight();
    for (int i = 0; i < 3; i++) begin
      issue_wr(7);
      tests++; if (bus.issue_ack_o !== 1'b1) begin fails++; $display("FAIL max_ack%0d got %b exp 1", i, bus.issue_ack_o); end
      tick();
    end
    tests++; if (bus.busy_o !== 32'h80) begin fails++; $display("FAIL max_busy got %h exp %h", bus.busy_o, 32'h80); end
    issue_wr(7);
    tests++; if (bus.stall_o !== 1'b1) begin fails++; $display("FAIL max_full_stall got %b exp 1", bus.stall_o); end
    wb(7);
    tests++; if (bus.issue_ack_o !== 1'b1) begin fails++; $display("FAIL max_bypass_ack got %b exp 1", bus.issue_ack_o); end
    tick();
    issue_wr(7);
    tests++; if (bus.stall_o !== 1'b1) begin fails++; $display("FAIL max_still_full got %b exp 1", bus.stall_o); end
    idle();
    for (int i = 0; i < 3; i++) begin
      wb(7);
      tick();
      tests++; if (bus.busy_o[7] !== (i < 2)) begin fails++; $display("FAIL max_drain%0d got %b exp %b", i, bus.busy_o[7], i < 2); end
    end
    tests++; if (bus.err_o !== 1'b0) begin fails++; $display("FAIL max_err got %b exp 0", bus.err_o); end
  endtask

  task automatic test_same_cycle();
    issue_wr(9);
    tick();
    issue_wr(9);
    wb(9);
    tests++; if (bus.issue_ack_o !== 1'b1) begin fails++; $display("FAIL same_ack got %b exp 1", bus.issue_ack_o); end
    tick();
    tests++; if (bus.busy_o !== 32'h200) begin fails++; $display("FAIL same_busy got %h exp %h", bus.busy_o, 32'h200); end
    wb(9);
    tick();
    tests++; if (bus.busy_o !== 32'h0) begin fails++; $display("FAIL same_drain got %h exp %h", bus.busy_o, 32'h0); end
    tests++; if (bus.err_o !== 1'b0) begin fails++; $display("FAIL same_err got %b exp 0", bus.err_o); end
  endtask

  task automatic test_underflow();
    wb(12);
    tests++; if (bus.err_o !== 1'b0) begin fails++; $display("FAIL unf_err_early got %b exp 0", bus.err_o); end
    tick();
    tests++; if (bus.err_o !== 1'b1) begin fails++; $display("FAIL unf_err got %b exp 1", bus.err_o); end
    tests++; if (bus.busy_o !== 32'h0) begin fails++; $display("FAIL unf_busy got %h exp %h", bus.busy_o, 32'h0); end
    bus.flush_i = 1;
    tick();
    tests++; if (bus.err_o !== 1'b1) begin fails++; $display("FAIL unf_flush_err got %b exp 1", bus.err_o); end
    do_reset();
    tests++; if (bus.err_o !== 1'b0) begin fails++; $display("FAIL unf_rst_err got %b exp 0", bus.err_o); end
  endtask

  task automatic test_flush();
    issue_wr(3);
    tick();
    issue_wr(4);
    tick();
    issue_wr(31);
    tick();
    tests++; if (bus.busy_o !== 32'h80000018) begin fails++; $display("FAIL flush_pre_busy got %h exp %h", bus.busy_o, 32'h80000018); end
    bus.flush_i = 1;
    issue_wr(8);
    tick();
    tests++; if (bus.busy_o !== 32'h0) begin fails++; $display("FAIL flush_busy got %h exp %h", bus.busy_o, 32'h0); end
    issue_wr(3);
    tick();
    issue_wr(3);
    tick();
    rst = 1;
    bus.flush_i = 1;
    tick();
    rst = 0;
    tests++; if (bus.busy_o !== 32'h0) begin fails++; $display("FAIL flush_rst_busy got %h exp %h", bus.busy_o, 32'h0); end
    bus.issue_valid_i = 1;
    bus.issue_rs1_use_i = 1;
    bus.issue_rs1_addr_i = 3;
    #1;
    tests++; if (bus.stall_o !== 1'b0) begin fails++; $display("FAIL flush_rst_stall got %b exp 0", bus.stall_o); end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_raw_bypass();
    test_x0();
    test_max_inflight();
    test_same_cycle();
    test_underflow();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rd_scoreboard.md
# rd_scoreboard

Register-write scoreboard for the pipelined CPU, directly downstream of destination-register selection in decode. Each issued instruction's selected destination index (rs1 field for the opcode[6:2]==5'b01010 class, rd field otherwise) is recorded as a pending write. The entry is released when the matching writeback retires. Decode stalls while any source register of the next instruction, or its destination counter, is not ready.

## Interface
Parameters:
- MAX_INFLIGHT, 3: maximum pending writes tracked per register. Must be 1..3.
- CNT_W, 2: per-register counter width. Must satisfy 2^CNT_W > MAX_INFLIGHT.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  synchronous clear of all pending entries (branch/exception flush)
- issue_valid_i  in  1  decode presents an instruction this cycle
- issue_wen_i  in  1  instruction writes a register
- issue_rd_addr_i  in  5  selected destination index
- issue_rs1_addr_i  in  5  source 1 index
- issue_rs2_addr_i  in  5  source 2 index
- issue_rs1_use_i  in  1  source 1 is read
- issue_rs2_use_i  in  1  source 2 is read
- wb_valid_i  in  1  writeback retires a register write this cycle
- wb_rd_addr_i  in  5  retiring destination index
- stall_o  out  1  decode must hold; the instruction is not accepted
- issue_ack_o  out  1  equals issue_valid_i & ~stall_o
- busy_o  out  32  bit n = register n has count > 0 (registered state)
- err_o  out  1  sticky; writeback to a register whose count is 0

## Operation
- State: 32 counters cnt[n] of CNT_W bits, plus err. cnt[0] is hard-wired to 0, so register 0 is never busy and never stalls.
- Release hit: rel[n] = wb_valid_i & (wb_rd_addr_i == n) & (n != 0).
- Effective count: eff[n] = cnt[n] - rel[n]. This is the writeback bypass; the register file writes before it is read.
- Stall: stall_o = issue_valid_i & any of the following:
  - issue_rs1_use_i & eff[rs1] != 0
  - issue_rs2_use_i & eff[rs2] != 0
  - issue_wen_i & rd != 0 & eff[rd] == MAX_INFLIGHT
- Issue hit: acq[n] = issue_ack_o & issue_wen_i & (issue_rd_addr_i == n) & (n != 0).
- Next-state update:
  - next cnt[n] = cnt[n] + acq[n] - rel[n].
  - acq and rel on the same register in one cycle leave the count unchanged.
- Writeback with cnt[n] == 0 (n != 0):
  - count stays 0; no underflow.
  - err is set and held until rst_i.
  - flush_i does not clear err.
- flush_i: all counters become 0 next cycle. Issue and writeback in the flush cycle are discarded. issue_ack_o is still driven combinationally, and decode must ignore it during a flush.
- rst_i has priority over flush_i. rst_i asserted mid-operation discards all pending entries.

## Timing
- Reset values: cnt all 0, busy_o = 32'h0, err_o = 0. stall_o and issue_ack_o follow their combinational equations; with inputs low both are 0.
- stall_o and issue_ack_o are combinational from current state and the same-cycle inputs. There is no added latency.
- busy_o reflects an issue or release one cycle after the accepting edge.
- A dependent instruction waiting in decode is accepted in the same cycle its producer's writeback is presented.
- Issue to the same rd on consecutive cycles is allowed up to MAX_INFLIGHT pending writes. The next one stalls until a release.

## Structure
- Shared CPU package holds:
  - REG_ADDR_W = 5
  - NUM_REGS = 32
  - the opcode constant 5'b01010 (rs1-as-destination class), so decode and this block agree on it.
- One sub-module, rd_counter: a single saturating up/down counter with acq, rel and flush inputs, producing count, nonzero and underflow-attempt outputs. It is instantiated for registers 1..31. The stall and select logic lives in the top level.

## Test plan
1. Reset, then issue rd=5 with wen. Next cycle busy_o = 32'h20. Then issue rs1=5, use=1 → stall_o = 1. Present wb rd=5 in that same cycle → stall_o = 0, issue_ack_o = 1, busy_o = 0 next cycle.
2. Issue rd=0 with wen, then rs1=0 → never stalls; busy_o stays 0.
3. With MAX_INFLIGHT = 3, issue rd=7 three times → cnt = 3. A fourth issue with rd=7 → stall_o = 1. Simultaneous wb rd=7 → accepted, cnt stays 3.
4. Same-cycle issue rd=9 and wb rd=9 with cnt[9] = 1 → cnt[9] remains 1; busy_o[9] stays 1.
5. Writeback rd=12 with cnt[12] = 0 → err_o = 1 next cycle, busy_o unchanged. Assert flush_i → err_o still 1. Assert rst_i → err_o = 0.
6. Pending writes on registers 3, 4 and 31; assert flush_i together with issue rd=8 → next cycle busy_o = 0, register 8 not recorded. Assert rst_i and flush_i together → all counters 0.
